// File: rtl/tdm_pkg.sv
// tdm_pkg: shared width, slot encodings and frame-state enum for the TDM demux
package tdm_pkg;
    localparam int WIDTH = 3;
    localparam int SLOTS = 4;
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam logic [1:0] SLOT0 = 2'b00;
    localparam logic [1:0] SLOT1 = 2'b01;
    localparam logic [1:0] SLOT2 = 2'b10;
    localparam logic [1:0] SLOT3 = 2'b11;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with clear, load-to-1 and wrapping increment, gated by en
module tdm_slot_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       load1,
    input  logic       inc,
    output logic [1:0] slot
);
    always_ff @(posedge clk)
        if (rst) slot <= 2'b00;
        else if (en) slot <= clr ? 2'b00 : load1 ? 2'b01 : inc ? slot + 2'd1 : slot;
endmodule

// File: rtl/tdm_demux4x3.sv
// tdm_demux4x3: rebuilds four channels from a slot-serialised stream, committing whole frames atomically
module tdm_demux4x3
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] w0,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3,
    output logic             f_valid,
    output logic             locked,
    output logic             err
);
    state_t state, state_n;
    logic [1:0] slot;
    logic clr, load1, inc, bad, commit;
    logic [WIDTH-1:0] sh0, sh1, sh2;

    tdm_slot_ctr u_ctr (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load1(load1), .inc(inc), .slot(slot)
    );

    always_comb begin
        state_n = state;
        clr = 1'b0;
        load1 = 1'b0;
        inc = 1'b0;
        bad = 1'b0;
        commit = 1'b0;
        if (en) begin
            if (state == HUNT) begin
                load1 = sync;
                state_n = sync ? LOCKED : HUNT;
            end else if (sync && slot != SLOT0) begin
                bad = 1'b1;
                load1 = 1'b1;
            end else if (!sync && slot == SLOT0) begin
                bad = 1'b1;
                clr = 1'b1;
                state_n = HUNT;
            end else if (slot == SLOT3) begin
                commit = 1'b1;
                clr = 1'b1;
            end else begin
                inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            {sh0, sh1, sh2} <= '0;
            {w0, w1, w2, w3} <= '0;
            f_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            f_valid <= commit;
            err <= bad;
            if (load1 || (inc && slot == SLOT0)) sh0 <= d;
            if (inc && slot == SLOT1) sh1 <= d;
            if (inc && slot == SLOT2) sh2 <= d;
            if (commit) {w0, w1, w2, w3} <= {sh0, sh1, sh2, d};
        end
    end

    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux4x3.sv
// tb_tdm_demux4x3: randomized and directed stimulus against a queue-based frame model with a scoreboard monitor
module tb_tdm_demux4x3;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, sync = 1'b0;
    logic [WIDTH-1:0] d = '0, w0, w1, w2, w3;
    logic f_valid, locked, err;

    always #5 clk = ~clk;

    tdm_demux4x3 dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .d(d),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .f_valid(f_valid), .locked(locked), .err(err)
    );

    typedef struct {
        logic [4*WIDTH-1:0] w;
        logic fv;
        logic lk;
        logic er;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;

    bit aligned = 0;
    int fq[$];
    logic [WIDTH-1:0] outs[4] = '{default: '0};

    function automatic void chk(string name, logic [4*WIDTH-1:0] act, logic [4*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model works on a list of words gathered since the last sync, not on a slot counter.
    task automatic step(input bit r, input bit e, input bit s, input int dv);
        exp_t x;
        logic [WIDTH-1:0] dw;
        @(negedge clk);
        dw = dv[WIDTH-1:0];
        rst = r; en = e; sync = s; d = dw;
        x.fv = 0;
        x.er = 0;
        if (r) begin
            aligned = 0;
            fq.delete();
            outs = '{default: '0};
        end else if (e) begin
            if (!aligned) begin
                if (s) begin aligned = 1; fq = '{int'(dw)}; end
            end else if (s) begin
                if (fq.size() != 0) x.er = 1;
                fq = '{int'(dw)};
            end else if (fq.size() == 0) begin
                x.er = 1;
                aligned = 0;
            end else begin
                fq.push_back(int'(dw));
                if (fq.size() == SLOTS) begin
                    for (int i = 0; i < SLOTS; i++) outs[i] = fq[i][WIDTH-1:0];
                    x.fv = 1;
                    fq.delete();
                end
            end
        end
        x.lk = aligned;
        x.w = {outs[3], outs[2], outs[1], outs[0]};
        sb.push_back(x);
    endtask

    task automatic frame(input int a, input int b, input int c, input int e4, input int gap);
        int v[4];
        v = '{a, b, c, e4};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, v[i]);
            for (int g = 0; g < gap; g++) step(0, 0, 1, $urandom_range(7));
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("words", {w3, w2, w1, w0}, x.w);
                chk("f_valid", {11'b0, f_valid}, {11'b0, x.fv});
                chk("locked", {11'b0, locked}, {11'b0, x.lk});
                chk("err", {11'b0, err}, {11'b0, x.er});
            end
        end
    end

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        frame(5, 2, 7, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        frame(5, 2, 7, 1, 2);
        step(0, 0, 0, 0);
        step(0, 1, 1, 3); step(0, 1, 0, 4);
        frame(6, 1, 2, 5, 0);
        frame(5, 2, 7, 1, 0);
        step(0, 1, 0, 4);
        step(0, 1, 0, 6); step(0, 1, 0, 3);
        frame(4, 4, 0, 7, 0);
        frame(5, 2, 7, 1, 0);
        step(0, 1, 1, 3); step(0, 1, 0, 6);
        step(1, 1, 0, 0);
        frame(1, 3, 5, 7, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, $urandom_range(7));
        for (int i = 0; i < 1500; i++)
            step($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 25, $urandom_range(7));
        for (int i = 0; i < 60; i++) frame($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(1));
        step(0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
